cplx_div_seq: RTL and testbench

//  Sequential complex divider C = A / B, the inverse operation of the complex multiplier in
//  the matrix-multiply datapath. Used for normalisation/back-substitution stages.

---
 rtl/cplx_div_seq.sv | 206 ++++++++++++++++++++
 tb/tb_cplx_div_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cplx_div_seq.sv
// cplx_div_seq: sequential complex divide C = A / B, signed fixed point with F fraction bits.
// Latency: accept edge k -> out_valid from edge k+W+F+2 (k+W+F+3 with CPLX_DIV_ROUND_EN).
// Backpressure: one op in flight; in_ready only when idle, result held until out_ready.
// Option macro CPLX_DIV_ROUND_EN: one guard-bit iteration, round to nearest (ties away from 0).

module cplx_div_seq #(
  parameter int W = 16,
  parameter int F = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] Ar,
  input  logic signed [W-1:0] Ai,
  input  logic signed [W-1:0] Br,
  input  logic signed [W-1:0] Bi,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W+F:0] Cr,
  output logic signed [W+F:0] Ci,
  output logic                div_by_zero
);

`ifdef CPLX_DIV_ROUND_EN
  localparam int GB = 1;            // guard bit for rounding
`else
  localparam int GB = 0;
`endif
  localparam int NIT = W + F + GB;      // restoring steps per component
  localparam int DW  = 2*W + F + GB;    // dividend width (|N| << F, plus guard)
  localparam int PW  = 2*W + 1;         // product / partial remainder width
  localparam int CW  = $clog2(NIT);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MULT = 3'd1;
  localparam logic [2:0] DIV  = 3'd2;
  localparam logic [2:0] FIN  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  // Captured operands, kept as one packed word.
  typedef struct packed {
    logic [W-1:0] ar;
    logic [W-1:0] ai;
    logic [W-1:0] br;
    logic [W-1:0] bi;
  } opnd_t;

  logic [2:0]     state;
  logic [CW-1:0]  cnt;
  opnd_t          op;
  logic [2*W-1:0] dsr;      // |B|^2, shared divisor
  logic           dz;       // |B|^2 == 0
  logic           sgn_r;
  logic           sgn_i;
  logic [PW-1:0]  rem_r;
  logic [PW-1:0]  rem_i;
  logic [NIT-1:0] q_r;      // low dividend bits shift out, quotient bits shift in
  logic [NIT-1:0] q_i;

  logic signed [PW-1:0] nr;
  logic signed [PW-1:0] ni;
  logic signed [PW-1:0] dsq;
  logic [PW-1:0]        mag_r;
  logic [PW-1:0]        mag_i;
  logic [DW-1:0]        dvd_r;
  logic [DW-1:0]        dvd_i;
  logic [W+F:0]         fmag_r;
  logic [W+F:0]         fmag_i;
  logic signed [W+F:0]  cr_n;
  logic signed [W+F:0]  ci_n;
`ifdef CPLX_DIV_ROUND_EN
  logic [NIT:0]         rnd_r;
  logic [NIT:0]         rnd_i;
`endif

  // Sign-extend a W-bit component to product width.
  function automatic logic signed [PW-1:0] sx(input logic [W-1:0] v);
    return {{(W+1){v[W-1]}}, v};
  endfunction

  // One restoring step: shift in next dividend bit, subtract divisor if it fits.
  // The partial remainder stays below |B|^2 <= 2^(2W-1), so its top bit is never needed.
  function automatic logic [PW+NIT-1:0] div_step(input logic [PW-1:0]  rem,
                                                 input logic [NIT-1:0] q,
                                                 input logic [2*W-1:0] dv);
    logic [PW-1:0] trial;
    trial = {rem[PW-2:0], q[NIT-1]};
    if (trial >= {1'b0, dv})
      return {trial - {1'b0, dv}, q[NIT-2:0], 1'b1};
    else
      return {trial, q[NIT-2:0], 1'b0};
  endfunction

  assign in_ready = (state == IDLE);

  // A*conj(B), |B|^2 and the sign/magnitude split of the numerators.
  always_comb begin
    nr    = sx(op.ar) * sx(op.br) + sx(op.ai) * sx(op.bi);
    ni    = sx(op.ai) * sx(op.br) - sx(op.ar) * sx(op.bi);
    dsq   = sx(op.br) * sx(op.br) + sx(op.bi) * sx(op.bi);
    mag_r = nr[PW-1] ? -nr : nr;
    mag_i = ni[PW-1] ? -ni : ni;
    // |N| <= 2^(2W-1) fits in 2W bits, so the top product bit is dropped.
    dvd_r = {mag_r[2*W-1:0], {(F+GB){1'b0}}};
    dvd_i = {mag_i[2*W-1:0], {(F+GB){1'b0}}};
  end

  // Final magnitude (optionally rounded) and sign application.
  always_comb begin
`ifdef CPLX_DIV_ROUND_EN
    // Quotient carries one extra LSB; adding half then dropping it rounds ties away from zero.
    rnd_r  = {1'b0, q_r} + {{NIT{1'b0}}, 1'b1};
    rnd_i  = {1'b0, q_i} + {{NIT{1'b0}}, 1'b1};
    fmag_r = rnd_r[NIT:1];
    fmag_i = rnd_i[NIT:1];
`else
    fmag_r = {1'b0, q_r};
    fmag_i = {1'b0, q_i};
`endif
    cr_n = '0;
    ci_n = '0;
    if (!dz) begin
      cr_n = sgn_r ? -fmag_r : fmag_r;
      ci_n = sgn_i ? -fmag_i : fmag_i;
    end
  end

  // Control FSM and iteration counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) state <= MULT;
        MULT: begin
          cnt   <= '0;
          state <= DIV;
        end
        DIV: begin
          if (cnt == CW'(NIT-1)) state <= FIN;
          else                   cnt   <= cnt + 1'b1;
        end
        FIN:  state <= DONE;
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture, product stage and the two restoring dividers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op    <= '0;
      dsr   <= '0;
      dz    <= 1'b0;
      sgn_r <= 1'b0;
      sgn_i <= 1'b0;
      rem_r <= '0;
      rem_i <= '0;
      q_r   <= '0;
      q_i   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) op <= {Ar, Ai, Br, Bi};
        MULT: begin
          dsr   <= dsq[2*W-1:0];
          dz    <= (dsq == '0);
          sgn_r <= nr[PW-1];
          sgn_i <= ni[PW-1];
          // Top W dividend bits seed the remainder; the rest feed one bit per step.
          rem_r <= {{(PW-W){1'b0}}, dvd_r[DW-1 -: W]};
          rem_i <= {{(PW-W){1'b0}}, dvd_i[DW-1 -: W]};
          q_r   <= dvd_r[NIT-1:0];
          q_i   <= dvd_i[NIT-1:0];
        end
        DIV: begin
          {rem_r, q_r} <= div_step(rem_r, q_r, dsr);
          {rem_i, q_i} <= div_step(rem_i, q_i, dsr);
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded in FIN, held through DONE until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      Cr          <= '0;
      Ci          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (state == FIN) begin
        Cr          <= cr_n;
        Ci          <= ci_n;
        div_by_zero <= dz;
        out_valid   <= 1'b1;
      end else if (state == DONE && out_ready) begin
        out_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cplx_div_seq.sv
// tb_cplx_div_seq: directed vectors for cplx_div_seq with a queue-based scoreboard.
// Expected quotients are hand-computed; a monitor checks values and latency on each result.
// Covers backpressure hold, busy-input rejection and mid-operation reset.

module tb_cplx_div_seq;

`ifdef CPLX_DIV_ROUND_EN
  localparam int LAT = 27;
  localparam logic RND = 1'b1;
`else
  localparam int LAT = 26;
  localparam logic RND = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] Ar, Ai, Br, Bi;
  logic               out_valid;
  logic               out_ready;
  logic signed [24:0] Cr, Ci;
  logic               div_by_zero;

  typedef struct {
    logic signed [24:0] cr;
    logic signed [24:0] ci;
    logic               dz;
    int                 acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   ov_seen = 0;

  cplx_div_seq #(.W(16), .F(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .Ar(Ar), .Ai(Ai), .Br(Br), .Bi(Bi),
    .out_valid(out_valid), .out_ready(out_ready),
    .Cr(Cr), .Ci(Ci), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: latency on first sight of out_valid, values on the handshake.
  always @(negedge clk) begin
    if (rst) begin
      ov_seen = 0;
    end else begin
      if (out_valid && !ov_seen) begin
        ov_seen = 1;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: out_valid with Cr=%0d Ci=%0d, expected no result", Cr, Ci);
        end else begin
          check("latency", cyc - exp_q[0].acc, LAT);
        end
      end
      if (out_valid && out_ready) begin
        ov_seen = 0;
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("Cr", Cr, e.cr);
          check("Ci", Ci, e.ci);
          check("div_by_zero", div_by_zero, e.dz);
        end
      end
    end
  end

  // Present one operand set, push the expected result on acceptance.
  task automatic issue(input logic signed [15:0] ar, ai, br, bi,
                       input logic signed [24:0] ecr, eci, input logic edz);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    Ar = ar; Ai = ai; Br = br; Bi = bi;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
    end else begin
      e.cr = ecr; e.ci = eci; e.dz = edz; e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    Ar = '0; Ai = '0; Br = '0; Bi = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_Cr", Cr, 0);
    check("rst_Ci", Ci, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;

    // Basic, extreme and zero-divisor vectors.
    issue(16'sd3, 16'sd4, 16'sd1, 16'sd2, 25'sd563, -25'sd102, 1'b0);
    drain();
    issue(-16'sd32768, -16'sd32768, -16'sd1, -16'sd1, 25'sd8388608, 25'sd0, 1'b0);
    drain();
    issue(16'sd100, -16'sd7, 16'sd0, 16'sd0, 25'sd0, 25'sd0, 1'b1);
    drain();

    // Back-to-back: each issue waits for in_ready.
    issue(-16'sd5, 16'sd3, 16'sd2, -16'sd1, RND ? -25'sd666 : -25'sd665, 25'sd51, 1'b0);
    issue(16'sd32767, -16'sd32768, 16'sd1, 16'sd0, 25'sd8388352, -25'sd8388608, 1'b0);
    issue(16'sd1, 16'sd0, -16'sd32768, -16'sd32768, 25'sd0, 25'sd0, 1'b0);
    issue(16'sd1, 16'sd1, 16'sd0, 16'sd3, 25'sd85, -25'sd85, 1'b0);
    issue(16'sd2, 16'sd0, 16'sd3, 16'sd0, RND ? 25'sd171 : 25'sd170, 25'sd0, 1'b0);
    issue(-16'sd2, 16'sd0, 16'sd3, 16'sd0, RND ? -25'sd171 : -25'sd170, 25'sd0, 1'b0);
    drain();

    // Consumer stalls for 10 cycles while a new request is offered.
    out_ready = 1'b0;
    issue(16'sd3, 16'sd4, 16'sd1, 16'sd2, 25'sd563, -25'sd102, 1'b0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall_wait_out_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        Ar = 16'sd9; Ai = 16'sd9; Br = 16'sd1; Bi = 16'sd1;
        in_valid = 1'b1;
      end
      @(negedge clk);
      check("stall_Cr", Cr, 563);
      check("stall_Ci", Ci, -102);
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_out_valid", out_valid, 0);
    drain();
    issue(16'sd7, 16'sd0, 16'sd2, 16'sd0, 25'sd896, 25'sd0, 1'b0);
    drain();

    // Reset in the middle of the divide, then a clean operation.
    issue(16'sd3, 16'sd4, 16'sd1, 16'sd2, 25'sd563, -25'sd102, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_hold_out_valid", out_valid, 0);
    check("midrst_hold_in_ready", in_ready, 1);
    rst = 1'b0;
    issue(16'sd3, 16'sd4, 16'sd1, 16'sd2, 25'sd563, -25'sd102, 1'b0);
    drain();

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
